// File: rtl/wdomain_full_ctrl.sv
// Write-domain pointer and full-flag controller for the asynchronous FIFO.
// Keeps binary/Gray write pointers, drives the memory write port, and derives
// full, fill level, almost_full and a sticky overflow flag from the read
// pointer synchronised into wclk.
module wdomain_full_ctrl #(
  parameter int unsigned DATASIZE  = 8,
  parameter int unsigned ADDRSIZE  = 4,
  parameter int unsigned AF_THRESH = 12
) (
  input  logic                wclk,
  input  logic                w_rst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   s_rptr,
  input  logic                ovf_clr,
  output logic                full,
  output logic                almost_full,
  output logic                overflow,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic [ADDRSIZE:0]   wlevel
);

  localparam int unsigned PW = ADDRSIZE + 1;

  // Elaboration-time parameter sanity checks
  if (ADDRSIZE < 2) begin : g_bad_addrsize
    $error("wdomain_full_ctrl: ADDRSIZE must be >= 2");
  end
  if (DATASIZE < 1) begin : g_bad_datasize
    $error("wdomain_full_ctrl: DATASIZE must be >= 1");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > (1 << ADDRSIZE))) begin : g_bad_afthresh
    $error("wdomain_full_ctrl: AF_THRESH out of range");
  end

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          full_q, full_d;
  logic          af_q, af_d;
  logic          ovf_q, ovf_d;

  logic [PW-1:0] wbnext;
  logic [PW-1:0] wgnext;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] full_cmp;
  logic [PW-1:0] level_next;
  logic          wen_int;

  // Gray-to-binary of the synchronised read pointer (prefix XOR from MSB)
  always_comb begin
    rbin_s         = '0;
    rbin_s[PW-1]   = s_rptr[PW-1];
    for (int i = int'(PW) - 2; i >= 0; i--) begin
      rbin_s[i] = rbin_s[i+1] ^ s_rptr[i];
    end
  end

  // Next-pointer, full compare, level and sticky overflow computation
  always_comb begin
    wen_int    = winc & ~full_q;
    wbnext     = wbin_q + PW'(wen_int);
    wgnext     = (wbnext >> 1) ^ wbnext;
    full_cmp   = {~s_rptr[PW-1:PW-2], s_rptr[PW-3:0]};
    level_next = wbnext - rbin_s;

    wbin_d   = wbnext;
    wptr_d   = wgnext;
    full_d   = (wgnext == full_cmp);
    wlevel_d = level_next;
    af_d     = (level_next >= PW'(AF_THRESH));
    // Set has priority over clear when both happen in the same cycle
    ovf_d    = (winc & full_q) | (ovf_q & ~ovf_clr);
  end

  // State registers, cleared asynchronously by w_rst
  always_ff @(posedge wclk or posedge w_rst) begin
    if (w_rst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      full_q   <= full_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
    end
  end

  // Memory write port is combinational from the registered pointer
  assign wen         = wen_int;
  assign waddr       = wbin_q[ADDRSIZE-1:0];
  assign wptr        = wptr_q;
  assign wlevel      = wlevel_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_wdomain_full_ctrl.sv
// Directed bench for wdomain_full_ctrl (ADDRSIZE=4, AF_THRESH=12).
module tb_wdomain_full_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned PW = AW + 1;
  localparam int unsigned NV = 22;

  logic          wclk;
  logic          w_rst;
  logic          winc;
  logic [PW-1:0] s_rptr;
  logic          ovf_clr;
  logic          full;
  logic          almost_full;
  logic          overflow;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [PW-1:0] wptr;
  logic [PW-1:0] wlevel;

  int tests;
  int errors;

  typedef struct {
    logic          winc;
    logic [PW-1:0] s_rptr;
    logic          clr;
    logic          e_wen;
    logic          e_full;
    logic          e_af;
    logic          e_ovf;
    logic [PW-1:0] e_wptr;
    logic [PW-1:0] e_lvl;
    logic [AW-1:0] e_waddr;
  } vec_t;

  vec_t tbl [NV];

  wdomain_full_ctrl #(
    .DATASIZE (8),
    .ADDRSIZE (AW),
    .AF_THRESH(12)
  ) dut (
    .wclk       (wclk),
    .w_rst      (w_rst),
    .winc       (winc),
    .s_rptr     (s_rptr),
    .ovf_clr    (ovf_clr),
    .full       (full),
    .almost_full(almost_full),
    .overflow   (overflow),
    .wen        (wen),
    .waddr      (waddr),
    .wptr       (wptr),
    .wlevel     (wlevel)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic vec_t mk(logic wi, logic [PW-1:0] sr, logic cl, logic ew,
                              logic ef, logic ea, logic eo, logic [PW-1:0] ep,
                              logic [PW-1:0] el, logic [AW-1:0] ed);
    vec_t v;
    v.winc = wi; v.s_rptr = sr; v.clr = cl; v.e_wen = ew; v.e_full = ef;
    v.e_af = ea; v.e_ovf = eo; v.e_wptr = ep; v.e_lvl = el; v.e_waddr = ed;
    return v;
  endfunction

  function automatic logic [PW-1:0] gray(logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; return just after the edge to sample outputs
  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    w_rst = 1'b1;
    step();
    w_rst = 1'b0;
  endtask

  initial begin
    tests  = 0;
    errors = 0;
    w_rst  = 1'b1;
    winc   = 1'b0;
    s_rptr = '0;
    ovf_clr = 1'b0;

    // Fill, overflow and drain-release vectors
    tbl[0]  = mk(1, 5'h00, 0, 1, 0, 0, 0, 5'h01, 5'd1,  4'd1);
    tbl[1]  = mk(1, 5'h00, 0, 1, 0, 0, 0, 5'h03, 5'd2,  4'd2);
    tbl[2]  = mk(1, 5'h00, 0, 1, 0, 0, 0, 5'h02, 5'd3,  4'd3);
    tbl[3]  = mk(1, 5'h00, 0, 1, 0, 0, 0, 5'h06, 5'd4,  4'd4);
    tbl[4]  = mk(1, 5'h00, 0, 1, 0, 0, 0, 5'h07, 5'd5,  4'd5);
    tbl[5]  = mk(1, 5'h00, 0, 1, 0, 0, 0, 5'h05, 5'd6,  4'd6);
    tbl[6]  = mk(1, 5'h00, 0, 1, 0, 0, 0, 5'h04, 5'd7,  4'd7);
    tbl[7]  = mk(1, 5'h00, 0, 1, 0, 0, 0, 5'h0C, 5'd8,  4'd8);
    tbl[8]  = mk(1, 5'h00, 0, 1, 0, 0, 0, 5'h0D, 5'd9,  4'd9);
    tbl[9]  = mk(1, 5'h00, 0, 1, 0, 0, 0, 5'h0F, 5'd10, 4'd10);
    tbl[10] = mk(1, 5'h00, 0, 1, 0, 0, 0, 5'h0E, 5'd11, 4'd11);
    tbl[11] = mk(1, 5'h00, 0, 1, 0, 1, 0, 5'h0A, 5'd12, 4'd12);
    tbl[12] = mk(1, 5'h00, 0, 1, 0, 1, 0, 5'h0B, 5'd13, 4'd13);
    tbl[13] = mk(1, 5'h00, 0, 1, 0, 1, 0, 5'h09, 5'd14, 4'd14);
    tbl[14] = mk(1, 5'h00, 0, 1, 0, 1, 0, 5'h08, 5'd15, 4'd15);
    tbl[15] = mk(1, 5'h00, 0, 1, 1, 1, 0, 5'h18, 5'd16, 4'd0);
    tbl[16] = mk(1, 5'h00, 0, 0, 1, 1, 1, 5'h18, 5'd16, 4'd0);
    tbl[17] = mk(0, 5'h00, 0, 0, 1, 1, 1, 5'h18, 5'd16, 4'd0);
    tbl[18] = mk(1, 5'h00, 1, 0, 1, 1, 1, 5'h18, 5'd16, 4'd0);
    tbl[19] = mk(0, 5'h00, 1, 0, 1, 1, 0, 5'h18, 5'd16, 4'd0);
    tbl[20] = mk(0, 5'h01, 0, 0, 0, 1, 0, 5'h18, 5'd15, 4'd0);
    tbl[21] = mk(1, 5'h01, 0, 1, 1, 1, 0, 5'h19, 5'd16, 4'd1);

    // Reset state while reset is held across edges
    step();
    step();
    chk("rst_wptr",   32'(wptr),        32'd0);
    chk("rst_full",   32'(full),        32'd0);
    chk("rst_af",     32'(almost_full), 32'd0);
    chk("rst_ovf",    32'(overflow),    32'd0);
    chk("rst_wlevel", 32'(wlevel),      32'd0);
    chk("rst_waddr",  32'(waddr),       32'd0);
    w_rst = 1'b0;

    // Table: wen checked before the edge, registered outputs after it
    for (int i = 0; i < int'(NV); i++) begin
      winc    = tbl[i].winc;
      s_rptr  = tbl[i].s_rptr;
      ovf_clr = tbl[i].clr;
      #1;
      chk($sformatf("v%0d_wen", i), 32'(wen), 32'(tbl[i].e_wen));
      step();
      chk($sformatf("v%0d_full", i),  32'(full),        32'(tbl[i].e_full));
      chk($sformatf("v%0d_af", i),    32'(almost_full), 32'(tbl[i].e_af));
      chk($sformatf("v%0d_ovf", i),   32'(overflow),    32'(tbl[i].e_ovf));
      chk($sformatf("v%0d_wptr", i),  32'(wptr),        32'(tbl[i].e_wptr));
      chk($sformatf("v%0d_lvl", i),   32'(wlevel),      32'(tbl[i].e_lvl));
      chk($sformatf("v%0d_waddr", i), 32'(waddr),       32'(tbl[i].e_waddr));
    end
    winc    = 1'b0;
    ovf_clr = 1'b0;

    // Wrap: read pointer trails write pointer by one for 40 writes
    s_rptr = '0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      logic [PW-1:0] b;
      b      = 5'(i);
      s_rptr = gray(b);
      winc   = 1'b1;
      step();
      chk($sformatf("wrap%0d_wptr", i), 32'(wptr),   32'(gray(5'(i + 1))));
      chk($sformatf("wrap%0d_full", i), 32'(full),   32'd0);
      chk($sformatf("wrap%0d_lvl", i),  32'(wlevel), 32'd1);
      if (i == 31) chk("wrap_back_to_zero", 32'(wptr), 32'd0);
    end
    winc = 1'b0;

    // Async reset mid-cycle at level 7
    s_rptr = '0;
    do_reset();
    winc = 1'b1;
    repeat (7) step();
    winc = 1'b0;
    chk("lvl7_pre", 32'(wlevel), 32'd7);
    #2;
    w_rst = 1'b1;
    #1;
    chk("arst_wptr",  32'(wptr),     32'd0);
    chk("arst_full",  32'(full),     32'd0);
    chk("arst_lvl",   32'(wlevel),   32'd0);
    chk("arst_ovf",   32'(overflow), 32'd0);
    chk("arst_waddr", 32'(waddr),    32'd0);
    w_rst = 1'b0;
    winc  = 1'b1;
    #1;
    chk("post_rst_waddr", 32'(waddr), 32'd0);
    chk("post_rst_wen",   32'(wen),   32'd1);
    step();
    chk("post_rst_wptr",  32'(wptr),  32'h01);

    // Almost-full boundary: level 12 -> 11 -> 12
    repeat (11) step();
    winc = 1'b0;
    chk("af12_lvl", 32'(wlevel),      32'd12);
    chk("af12_af",  32'(almost_full), 32'd1);
    s_rptr = 5'h01;
    step();
    chk("af11_lvl", 32'(wlevel),      32'd11);
    chk("af11_af",  32'(almost_full), 32'd0);
    winc = 1'b1;
    step();
    winc = 1'b0;
    chk("af12b_lvl",  32'(wlevel),      32'd12);
    chk("af12b_af",   32'(almost_full), 32'd1);
    chk("af12b_wptr", 32'(wptr),        32'h0B);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
